// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: chooses the next PC and drives IF/ID and ID/EX
// pipeline controls for boot, sequential fetch, load-use stalls and redirects.
// Optional feature macro: PC_FETCH_CTRL_PERF_EN adds saturating stall/flush
// cycle counters (stall_cnt, flush_cnt).
module pc_fetch_ctrl #(
  parameter int unsigned     PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VEC    = '0,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            imem_ready,
  input  logic            stall_req,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] pc_next,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [1:0]      state
`ifdef PC_FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  localparam int unsigned     CNT_W      = 2;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the redirect cycle itself.
  localparam bit              SKIP_REDIR = (FLUSH_CYCLES == 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and flush counter register; reset forces BOOT immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; outputs react to inputs in the same cycle
  // so a redirect steers the PC without losing a fetch slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_next     = '0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    case (state_q)
      BOOT: begin
        pc_next    = RESET_VEC;
        pc_we      = 1'b1;
        ifid_flush = 1'b1;
        cnt_d      = '0;
        state_d    = RUN;
      end

      RUN, STALL: begin
        if (br_taken || jmp_valid) begin
          pc_next    = br_taken ? br_target : jmp_target;
          pc_we      = 1'b1;
          ifid_flush = 1'b1;
          if (SKIP_REDIR) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d   = FLUSH_LOAD;
            state_d = REDIR;
          end
        end else if (stall_req) begin
          idex_bubble = 1'b1;
          state_d     = STALL;
        end else if (state_q == STALL) begin
          // Release cycle: stall dropped, pipeline stays quiet for one cycle.
          state_d = RUN;
        end else if (imem_ready) begin
          pc_next = pc_cur + PC_W'(1);
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end

      REDIR: begin
        ifid_flush = 1'b1;
        pc_we      = 1'b1;
        if (br_taken) begin
          // A resolved branch overrides the flush in progress and restarts it.
          pc_next = br_target;
          cnt_d   = FLUSH_LOAD;
        end else begin
          pc_next = pc_cur + PC_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  assign state = 2'(state_q);

`ifdef PC_FETCH_CTRL_PERF_EN
  // Saturating counts of STALL cycles and non-boot flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state_q == STALL) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (ifid_flush && (state_q != BOOT) && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed spot checks plus randomized
// traffic compared every cycle against a behavioural reference model.
module tb_pc_fetch_ctrl;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] RV   = 32'h0000_0100;
  localparam int          FC   = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic        stall_req;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  state;
`ifdef PC_FETCH_CTRL_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pc_fetch_ctrl #(
    .PC_W        (PC_W),
    .RESET_VEC   (RV),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .imem_ready (imem_ready),
    .stall_req  (stall_req),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .pc_next    (pc_next),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_bubble(idex_bubble),
    .state      (state)
`ifdef PC_FETCH_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what phase the fetch unit is in, in plain terms.
  bit          m_boot;
  int          m_flush_left;   // flush cycles still owed after the current one
  bit          m_stalled;
  int          m_stall_tot;
  int          m_flush_tot;
  logic [31:0] pc_reg;         // bench-side PC register

  logic [31:0] e_pc_next;
  bit          e_pc_we, e_ifid_we, e_flush, e_bubble;
  int          e_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot       = 1'b1;
    m_flush_left = 0;
    m_stalled    = 1'b0;
    m_stall_tot  = 0;
    m_flush_tot  = 0;
  endtask

  task automatic model_eval();
    e_pc_next = '0;
    e_pc_we   = 0;
    e_ifid_we = 0;
    e_flush   = 0;
    e_bubble  = 0;
    if (m_boot) begin
      e_state = 0; e_pc_next = RV; e_pc_we = 1; e_flush = 1;
    end else if (m_flush_left > 0) begin
      e_state = 3; e_pc_we = 1; e_flush = 1;
      e_pc_next = br_taken ? br_target : pc_cur + 32'd1;
    end else begin
      e_state = m_stalled ? 2 : 1;
      if (br_taken || jmp_valid) begin
        e_pc_next = br_taken ? br_target : jmp_target;
        e_pc_we = 1; e_flush = 1;
      end else if (stall_req) begin
        e_bubble = 1;
      end else if (!m_stalled && imem_ready) begin
        e_pc_next = pc_cur + 32'd1; e_pc_we = 1; e_ifid_we = 1;
      end
    end
  endtask

  task automatic model_advance();
    if (e_state == 2 && m_stall_tot < 65535) m_stall_tot++;
    if (e_flush && e_state != 0 && m_flush_tot < 65535) m_flush_tot++;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left = br_taken ? FC - 1 : m_flush_left - 1;
    end else if (br_taken || jmp_valid) begin
      m_flush_left = FC - 1;
      m_stalled    = 1'b0;
    end else begin
      m_stalled = stall_req;
    end
  endtask

  // One clock cycle: apply inputs after the edge, compare against the model.
  task automatic run_cycle(input bit bt, input logic [31:0] btg, input bit jv,
                           input logic [31:0] jtg, input bit sr, input bit ir);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    br_taken   = bt;
    br_target  = btg;
    jmp_valid  = jv;
    jmp_target = jtg;
    stall_req  = sr;
    imem_ready = ir;
    pc_cur     = pc_reg;
    #1;
    model_eval();
    check("pc_next", pc_next, e_pc_next);
    check("pc_we", 32'(pc_we), 32'(e_pc_we));
    check("ifid_we", 32'(ifid_we), 32'(e_ifid_we));
    check("ifid_flush", 32'(ifid_flush), 32'(e_flush));
    check("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
    check("state", 32'(state), 32'(e_state));
`ifdef PC_FETCH_CTRL_PERF_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall_tot));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush_tot));
`endif
    model_advance();
    if (e_pc_we) pc_reg = e_pc_next;
  endtask

  task automatic idle();
    run_cycle(0, '0, 0, '0, 0, 1);
  endtask

  // Assert reset mid-cycle and confirm BOOT values appear without a clock edge.
  task automatic async_reset();
    #1;
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_next", pc_next, RV);
    check("rst_pc_we", 32'(pc_we), 32'd1);
    check("rst_ifid_flush", 32'(ifid_flush), 32'd1);
    check("rst_ifid_we", 32'(ifid_we), 32'd0);
    check("rst_idex_bubble", 32'(idex_bubble), 32'd0);
`ifdef PC_FETCH_CTRL_PERF_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_run;
    rst = 1'b0; pc_cur = '0; imem_ready = 1'b0; stall_req = 1'b0;
    br_taken = 1'b0; br_target = '0; jmp_valid = 1'b0; jmp_target = '0;
    pc_reg = '0;
    #3;
    check("reset_state", 32'(state), 32'd0);
    check("reset_pc_next", pc_next, RV);
    check("reset_pc_we", 32'(pc_we), 32'd1);
    check("reset_ifid_flush", 32'(ifid_flush), 32'd1);
    check("reset_ifid_we", 32'(ifid_we), 32'd0);
    model_reset();

    // Boot then sequential fetch.
    idle();
    check("boot_pc", pc_next, 32'h100);
    idle();
    check("seq1_pc", pc_next, 32'h101);
    check("seq1_ifid_we", 32'(ifid_we), 32'd1);
    idle();
    check("seq2_pc", pc_next, 32'h102);

    // Taken branch with a two-cycle flush.
    run_cycle(1, 32'h40, 0, '0, 0, 1);
    check("br_pc", pc_next, 32'h40);
    check("br_flush", 32'(ifid_flush), 32'd1);
    idle();
    check("redir_state", 32'(state), 32'd3);
    check("redir_flush", 32'(ifid_flush), 32'd1);
    check("redir_pc", pc_next, 32'h41);
    idle();
    check("after_redir_state", 32'(state), 32'd1);
    check("after_redir_flush", 32'(ifid_flush), 32'd0);
    check("after_redir_pc", pc_next, 32'h42);

    // Branch wins over jump.
    run_cycle(1, 32'h10, 1, 32'h20, 0, 1);
    check("prio_pc", pc_next, 32'h10);
    idle(); idle();

    // Three-cycle stall, quiet release cycle, then resume.
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, '0, 0, '0, 1, 1);
      check("stall_pc_we", 32'(pc_we), 32'd0);
      check("stall_bubble", 32'(idex_bubble), 32'd1);
    end
    check("stall_state", 32'(state), 32'd2);
    idle();
    check("release_bubble", 32'(idex_bubble), 32'd0);
    idle();
    check("resume_pc", pc_next, 32'h13);

    // Jump taken from STALL.
    run_cycle(0, '0, 0, '0, 1, 1);
    run_cycle(0, '0, 1, 32'h500, 1, 1);
    check("stall_jmp_pc", pc_next, 32'h500);
    idle(); idle();

    // PC wrap.
    pc_reg = 32'hFFFF_FFFF;
    idle();
    check("wrap_pc", pc_next, 32'h0);

    // Branch restarts a flush; jump in flush ignored.
    run_cycle(1, 32'h200, 0, '0, 0, 1);
    run_cycle(1, 32'h300, 0, '0, 0, 1);
    check("restart_pc", pc_next, 32'h300);
    run_cycle(0, '0, 1, 32'h900, 0, 1);
    check("jmp_ignored_pc", pc_next, 32'h301);
    idle();
    check("restart_exit_state", 32'(state), 32'd1);

    // Memory not ready holds everything.
    run_cycle(0, '0, 0, '0, 0, 0);
    check("nready_pc_we", 32'(pc_we), 32'd0);

    // Reset during redirect.
    run_cycle(1, 32'h80, 0, '0, 0, 1);
    idle();
    check("pre_rst_state", 32'(state), 32'd3);
    async_reset();
    idle();
    check("post_rst_boot_pc", pc_next, RV);

    // Randomized traffic.
    stall_run = 0;
    for (int n = 0; n < 3000; n++) begin
      bit bt, jv, sr, ir;
      if (($urandom % 50) == 0) pc_reg = (($urandom % 2) == 0) ? 32'hFFFF_FFFF : $urandom;
      bt = (($urandom % 10) == 0);
      jv = (($urandom % 8) == 0);
      if (stall_run == 0 && ($urandom % 12) == 0) stall_run = $urandom_range(1, 5);
      sr = (stall_run > 0);
      if (stall_run > 0) stall_run--;
      ir = (($urandom % 7) != 0);
      run_cycle(bt, $urandom, jv, $urandom, sr, ir);
      if (($urandom % 150) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
